instr_fetch_unit: RTL and testbench

//  Instruction fetch stage of the MIPS core, directly upstream of the control decoder.

---
 rtl/mips_pkg.sv | 18 +
 rtl/next_pc_calc.sv | 32 +++
 rtl/instr_fetch_unit.sv | 117 +++++++++++
 tb/tb_instr_fetch_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: fetch FSM states, datapath width and the
// opcodes the fetch stage and the control decoder agree on.
package mips_pkg;

    localparam int INSTR_W = 32;

    localparam logic [5:0] OPC_J   = 6'b000010;
    localparam logic [5:0] OPC_JAL = 6'b000011;
    localparam logic [5:0] OPC_BEQ = 6'b000100;

    typedef enum logic [1:0] {
        BOOT,
        REQ,
        WAIT_MEM,
        HOLD
    } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, beq target or j/jal target.
// Jump outranks a taken branch; all arithmetic wraps modulo 2^32.
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [INSTR_W-1:0] pc,
    input  logic [25:0]        instrIndex,
    input  logic               jump,
    input  logic               branch,
    input  logic               aluZero,
    output logic [INSTR_W-1:0] nextPc,
    output logic [INSTR_W-1:0] pcPlus4
);

    logic [INSTR_W-1:0] branchOffset;
    logic [INSTR_W-1:0] jumpTarget;

    assign pcPlus4      = pc + 32'd4;
    // Low 16 bits of the index field double as the beq immediate.
    assign branchOffset = {{14{instrIndex[15]}}, instrIndex[15:0], 2'b00};
    assign jumpTarget   = {pcPlus4[31:28], instrIndex, 2'b00};

    always_comb begin
        nextPc = pcPlus4;
        if (jump) begin
            nextPc = jumpTarget;
        end else if (branch && aluZero) begin
            nextPc = pcPlus4 + branchOffset;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches over a req/ready handshake and holds the
// word for decode until it is retired with instr_ack.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [15:0] TIMEOUT  = 16'd1024
)
(
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [INSTR_W-1:0] imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [5:0]         opcode,
    output logic [INSTR_W-1:0] pc,
    output logic [INSTR_W-1:0] pc_plus4,
    input  logic               instr_ack,
    input  logic               jump,
    input  logic               branch,
    input  logic               alu_zero,
    output logic               fetch_err
);

    fetch_state_t       state;
    logic [INSTR_W-1:0] pcQ;
    logic [INSTR_W-1:0] instrQ;
    logic [15:0]        timeoutCount;
    logic               imemReqQ;
    logic               instrValidQ;
    logic               fetchErrQ;
    logic [INSTR_W-1:0] nextPc;
    logic [INSTR_W-1:0] pcPlus4;

    generate
        if (RESET_PC[1:0] != 2'b00) begin : gBadResetPc
            $error("instr_fetch_unit: RESET_PC must be word aligned");
        end
    endgenerate

    next_pc_calc uNextPc (
        .pc        (pcQ),
        .instrIndex(instrQ[25:0]),
        .jump      (jump),
        .branch    (branch),
        .aluZero   (alu_zero),
        .nextPc    (nextPc),
        .pcPlus4   (pcPlus4)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= BOOT;
            pcQ          <= RESET_PC;
            instrQ       <= '0;
            timeoutCount <= '0;
            imemReqQ     <= 1'b0;
            instrValidQ  <= 1'b0;
            fetchErrQ    <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state    <= REQ;
                    imemReqQ <= 1'b1;
                end
                REQ: begin
                    timeoutCount <= '0;
                    if (imem_ready) begin
                        instrQ      <= imem_rdata;
                        state       <= HOLD;
                        imemReqQ    <= 1'b0;
                        instrValidQ <= 1'b1;
                    end else begin
                        state <= WAIT_MEM;
                    end
                end
                WAIT_MEM: begin
                    if (imem_ready) begin
                        instrQ      <= imem_rdata;
                        state       <= HOLD;
                        imemReqQ    <= 1'b0;
                        instrValidQ <= 1'b1;
                    end else if (timeoutCount == TIMEOUT - 16'd1) begin
                        // Saturate here: the error is sticky and the request stays up.
                        fetchErrQ <= 1'b1;
                    end else begin
                        timeoutCount <= timeoutCount + 16'd1;
                    end
                end
                HOLD: begin
                    if (instr_ack) begin
                        pcQ         <= nextPc;
                        state       <= REQ;
                        imemReqQ    <= 1'b1;
                        instrValidQ <= 1'b0;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

    assign imem_req    = imemReqQ;
    assign imem_addr   = pcQ;
    assign instr_valid = instrValidQ;
    assign instr       = instrQ;
    assign opcode      = instrQ[31:26];
    assign pc          = pcQ;
    assign pc_plus4    = pcPlus4;
    assign fetch_err   = fetchErrQ;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a vector table drives fetch/ack
// transactions with a queue of expected fetch addresses, plus hand sequences.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_ack;
    logic        jump;
    logic        branch;
    logic        alu_zero;
    logic        fetch_err;

    logic        rstNB;
    logic        imemReqB;
    logic [31:0] imemAddrB;
    logic        imemReadyB;
    logic [31:0] imemRdataB;
    logic        instrValidB;
    logic [31:0] instrB;
    logic [5:0]  opcodeB;
    logic [31:0] pcB;
    logic [31:0] pcPlus4B;
    logic        instrAckB;
    logic        fetchErrB;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(16'd8)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .opcode(opcode),
        .pc(pc), .pc_plus4(pc_plus4),
        .instr_ack(instr_ack), .jump(jump), .branch(branch), .alu_zero(alu_zero),
        .fetch_err(fetch_err)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
        .clk(clk), .rst_n(rstNB),
        .imem_req(imemReqB), .imem_addr(imemAddrB),
        .imem_ready(imemReadyB), .imem_rdata(imemRdataB),
        .instr_valid(instrValidB), .instr(instrB), .opcode(opcodeB),
        .pc(pcB), .pc_plus4(pcPlus4B),
        .instr_ack(instrAckB), .jump(1'b0), .branch(1'b0), .alu_zero(1'b0),
        .fetch_err(fetchErrB)
    );

    typedef struct {
        logic [31:0] word;
        logic        jump;
        logic        branch;
        logic        zero;
        int          lat;
        int          ackDelay;
        logic [31:0] expNext;
    } vec_t;

    vec_t        vecs[10];
    logic [31:0] expQ[$];
    int          nVec = 0;
    int          nErr = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic waitReq(output int waited);
        waited = 0;
        while (!imem_req && waited < 20) begin
            @(negedge clk);
            waited++;
        end
    endtask

    initial begin
        int          waited;
        logic [31:0] expPc;
        logic [31:0] w;
        vec_t        v;

        //            word          j     b     z     lat ackD  next
        vecs[0] = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0000_0004};
        vecs[1] = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0000_0008};
        vecs[2] = '{32'h1022_0003, 1'b0, 1'b1, 1'b0, 0, 0, 32'h0000_000C};
        vecs[3] = '{32'h1022_0003, 1'b0, 1'b0, 1'b1, 0, 0, 32'h0000_0010};
        vecs[4] = '{32'h1022_FFFF, 1'b0, 1'b1, 1'b1, 0, 0, 32'h0000_0010};
        vecs[5] = '{32'h1022_0003, 1'b0, 1'b1, 1'b0, 3, 5, 32'h0000_0014};
        vecs[6] = '{32'h0800_0004, 1'b1, 1'b0, 1'b0, 1, 0, 32'h0000_0010};
        vecs[7] = '{32'h1022_0003, 1'b0, 1'b1, 1'b1, 2, 1, 32'h0000_0020};
        vecs[8] = '{32'h0C10_0000, 1'b1, 1'b1, 1'b1, 0, 0, 32'h0040_0000};
        vecs[9] = '{32'h0800_0040, 1'b1, 1'b1, 1'b1, 0, 2, 32'h0000_0100};

        rst_n = 1'b0; rstNB = 1'b0;
        imem_ready = 1'b0; imem_rdata = '0; instr_ack = 1'b0;
        jump = 1'b0; branch = 1'b0; alu_zero = 1'b0;
        imemReadyB = 1'b0; imemRdataB = '0; instrAckB = 1'b0;
        repeat (3) @(negedge clk);

        check1("rst_req", imem_req, 1'b0);
        check1("rst_valid", instr_valid, 1'b0);
        check32("rst_pc", pc, 32'h0);
        check32("rst_instr", instr, 32'h0);
        check32("rst_pc_plus4", pc_plus4, 32'h4);
        check1("rst_err", fetch_err, 1'b0);

        rst_n = 1'b1;
        expQ.push_back(32'h0000_0000);

        for (int i = 0; i < 10; i++) begin
            v = vecs[i];
            waitReq(waited);
            check1($sformatf("v%0d_req_seen", i), imem_req, 1'b1);
            check32($sformatf("v%0d_req_latency", i), waited, (i == 0) ? 32'd1 : 32'd0);
            if (expQ.size() == 0) begin
                check1($sformatf("v%0d_scoreboard_empty", i), 1'b1, 1'b0);
                expPc = 32'hx;
            end else begin
                expPc = expQ.pop_front();
            end
            check32($sformatf("v%0d_imem_addr", i), imem_addr, expPc);

            // Stray ack/jump while fetching must be ignored.
            for (int k = 0; k < v.lat; k++) begin
                instr_ack = 1'b1; jump = 1'b1;
                @(negedge clk);
                check1($sformatf("v%0d_req_wait%0d", i, k), imem_req, 1'b1);
            end
            instr_ack = 1'b0; jump = 1'b0;
            imem_ready = 1'b1; imem_rdata = v.word;
            @(negedge clk);
            imem_ready = 1'b0; imem_rdata = '0;
            w = v.word;
            check1($sformatf("v%0d_valid", i), instr_valid, 1'b1);
            check32($sformatf("v%0d_instr", i), instr, w);
            check32($sformatf("v%0d_opcode", i), {26'b0, opcode}, {26'b0, w[31:26]});
            check32($sformatf("v%0d_pc", i), pc, expPc);
            check32($sformatf("v%0d_pc_plus4", i), pc_plus4, expPc + 32'd4);
            check1($sformatf("v%0d_req_low", i), imem_req, 1'b0);

            // Held instruction must ignore memory responses and unacked controls.
            for (int k = 0; k < v.ackDelay; k++) begin
                imem_ready = 1'b1; imem_rdata = ~w;
                jump = 1'b1; branch = 1'b1; alu_zero = 1'b1;
                @(negedge clk);
                check1($sformatf("v%0d_hold_valid%0d", i, k), instr_valid, 1'b1);
                check32($sformatf("v%0d_hold_instr%0d", i, k), instr, w);
                check32($sformatf("v%0d_hold_pc%0d", i, k), pc, expPc);
                check1($sformatf("v%0d_hold_req%0d", i, k), imem_req, 1'b0);
            end
            imem_ready = 1'b0; imem_rdata = '0;

            instr_ack = 1'b1; jump = v.jump; branch = v.branch; alu_zero = v.zero;
            expQ.push_back(v.expNext);
            $display("vec %0d: pc=%h instr=%h j=%b b=%b z=%b -> expect %h",
                     i, expPc, w, v.jump, v.branch, v.zero, v.expNext);
            @(negedge clk);
            instr_ack = 1'b0; jump = 1'b0; branch = 1'b0; alu_zero = 1'b0;
            check1($sformatf("v%0d_valid_drop", i), instr_valid, 1'b0);
        end

        // Memory never answers: the sticky error fires after 8 cycles in WAIT_MEM.
        waitReq(waited);
        check32("to_latency", waited, 32'd0);
        expPc = (expQ.size() != 0) ? expQ.pop_front() : 32'hx;
        check32("to_imem_addr", imem_addr, expPc);
        check1("to_err_before", fetch_err, 1'b0);
        repeat (8) @(negedge clk);
        check1("to_err_at_7", fetch_err, 1'b0);
        @(negedge clk);
        check1("to_err_at_8", fetch_err, 1'b1);
        repeat (4) @(negedge clk);
        check1("to_err_sticky", fetch_err, 1'b1);
        check1("to_req_held", imem_req, 1'b1);
        imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ready = 1'b0;
        check1("to_late_valid", instr_valid, 1'b1);
        check32("to_late_instr", instr, 32'hDEAD_BEEF);
        check1("to_err_kept", fetch_err, 1'b1);
        $display("timeout: addr=%h err=%b instr=%h", imem_addr, fetch_err, instr);

        // Wrapping PC and reset during WAIT_MEM on the second instance.
        rstNB = 1'b1;
        waited = 0;
        while (!imemReqB && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check32("wrap_req_latency", waited, 32'd1);
        check32("wrap_addr", imemAddrB, 32'hFFFF_FFFC);
        imemReadyB = 1'b1; imemRdataB = 32'h0000_0000;
        @(negedge clk);
        imemReadyB = 1'b0;
        check1("wrap_valid", instrValidB, 1'b1);
        check32("wrap_pc_plus4", pcPlus4B, 32'h0000_0000);
        instrAckB = 1'b1;
        @(negedge clk);
        instrAckB = 1'b0;
        check1("wrap_req_next", imemReqB, 1'b1);
        check32("wrap_next_addr", imemAddrB, 32'h0000_0000);
        $display("wrap: pc FFFFFFFC -> next addr %h", imemAddrB);
        @(negedge clk);
        rstNB = 1'b0;
        #1;
        check1("midrst_req", imemReqB, 1'b0);
        check1("midrst_valid", instrValidB, 1'b0);
        check32("midrst_pc", pcB, 32'hFFFF_FFFC);
        @(negedge clk);
        rstNB = 1'b1;
        @(negedge clk);
        check1("midrst_restart_req", imemReqB, 1'b1);
        check32("midrst_restart_addr", imemAddrB, 32'hFFFF_FFFC);
        $display("midrst: restart addr %h", imemAddrB);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
